reset_ctrl: RTL
===============

RESET_CTRL -- requirements
Module: reset_ctrl

Interface
REQ-001 SHALL expose parameter STRETCH, default 16, cycles sys_rst stays high after the last request drops (1..255).
REQ-002 SHALL expose parameter DEBOUNCE, default 200, consecutive low cycles required to accept btn_n (1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  power-on reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port wdt_req  input  1  watchdog reset request, active-high level.
REQ-006 SHALL have port btn_n  input  1  external reset button, asynchronous, active-low.
REQ-007 SHALL have port cs  input  1  register select.
REQ-008 SHALL have port we  input  1  write strobe, qualified by cs.
REQ-009 SHALL have port addr  input  2  register index.
REQ-010 SHALL have port din  input  8  write data.
REQ-011 SHALL have port dout  output  8  read data, combinational from addr.
REQ-012 SHALL have port sys_rst  output  1  registered active-high reset to CPU, watchdog and peripherals.

Function
REQ-013 SHALL synchronise btn_n through two flops before any use.
REQ-014 SHALL raise btn_evt when synchronised btn_n has been low for DEBOUNCE consecutive cycles; any high sample clears the debounce counter.
REQ-015 SHALL hold btn_evt active while the button stays low; re-arm only after synchronised btn_n returns high.
REQ-016 SHALL generate sw_evt for one cycle on a write of 0xA5 to addr 1; other values to addr 1 are ignored.
REQ-017 SHALL implement FSM states RUN (sys_rst=0), HOLD (sys_rst=1, any request active), STRETCH (sys_rst=1, counting).
REQ-018 SHALL transition RUN->HOLD on the cycle after wdt_req, btn_evt or sw_evt is sampled high (one-cycle latency).
REQ-019 SHALL transition HOLD->STRETCH, clearing the 8-bit stretch counter, when wdt_req and btn_evt are both low.
REQ-020 SHALL transition STRETCH->RUN when the counter reaches STRETCH-1; any new request in STRETCH returns to HOLD.
REQ-021 SHALL latch cause register (addr 0) bits: [0] power-on, [1] watchdog, [2] button, [3] software, [7:4] read 0.
REQ-022 SHALL set every cause bit whose source is active in a cycle, simultaneous sources setting all matching bits.
REQ-023 SHALL clear cause bits by write-1-to-clear at addr 0; a set in the same cycle wins over the clear.
REQ-024 SHALL count RUN->HOLD entries in an 8-bit saturating reset counter (addr 2), stopping at 0xFF; write to addr 2 clears it.
REQ-025 SHALL return {6'b0, state[1:0]} at addr 3 (RUN=0, HOLD=1, STRETCH=2); addr 1 reads 0x00.
REQ-026 SHALL ignore all register writes while sys_rst=1.
REQ-027 SHALL keep cause register and reset counter unaffected by sys_rst; only rst_n clears them.

Reset
REQ-028 SHALL on rst_n low: state=STRETCH, stretch counter=0, sys_rst=1, cause=0x01, reset counter=0x00, debounce counter=0, sync flops=1.
REQ-029 SHALL on rst_n low mid-sequence abandon HOLD/STRETCH and restart per REQ-028.
REQ-030 SHALL, after rst_n release with no requests, deassert sys_rst exactly STRETCH cycles later.

Structure
REQ-031 SHALL place state encodings, register addresses (CAUSE=0, SWRST=1, COUNT=2, STATUS=3), key 0xA5 and cause bit indices in the shared SoC package.
REQ-032 SHALL implement synchroniser plus debounce as sub-module reset_debounce (clk, rst_n, in_n, evt); FSM and registers stay in reset_ctrl.

Verification
REQ-033 SHALL test power-on: rst_n low 3 cycles then high, STRETCH=16 -> sys_rst falls 16 cycles after release, cause=0x01, count=0.
REQ-034 SHALL test watchdog: write 0x0F to addr 0, pulse wdt_req 1 cycle -> sys_rst=1 next cycle, held 1+16 cycles, cause=0x02, count=1.
REQ-035 SHALL test button: btn_n low 150 cycles (DEBOUNCE=200) -> no reset; low 300 cycles -> sys_rst rises 203 cycles after fall, releases 16 after btn_n high+sync, cause bit2 set.
REQ-036 SHALL test software: write 0x5A to addr 1 -> no reset; write 0xA5 -> sys_rst next cycle, cause bit3 set, addr 3 reads 1 then 2 then 0.
REQ-037 SHALL test collision: wdt_req during STRETCH at counter 10 -> back to HOLD, full 16-cycle stretch restarts; wdt_req and W1C 0x02 same cycle -> bit1 remains set.
REQ-038 SHALL test saturation: 256 watchdog resets -> addr 2 reads 0xFF; write to addr 2 while sys_rst=1 ignored, in RUN clears to 0x00.

Source files
------------

// File: rtl/reset_ctrl_pkg.sv
// reset_ctrl_pkg: shared definitions for the reset controller.
//   - FSM state encoding (also returned on the STATUS register)
//   - register map, software-reset key, cause bit positions
package reset_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_STRETCH = 2'd2
   } rst_state_e;

   localparam logic [1:0] ADDR_CAUSE  = 2'd0;
   localparam logic [1:0] ADDR_SWRST  = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam logic [7:0] SWRST_KEY = 8'hA5;

   localparam int CAUSE_W   = 4;
   localparam int CAUSE_POR = 0;
   localparam int CAUSE_WDT = 1;
   localparam int CAUSE_BTN = 2;
   localparam int CAUSE_SW  = 3;

   localparam logic [CAUSE_W-1:0] CAUSE_RST_VAL = 4'b0001;

endpackage

// File: rtl/reset_debounce.sv
// reset_debounce: two-flop synchroniser plus low-level debounce for an
// asynchronous active-low button.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   in_n  : raw asynchronous active-low input
//   evt   : high once the synchronised input has been low for DEBOUNCE
//           consecutive cycles; stays high while it remains low
module reset_debounce #(
   parameter int unsigned DEBOUNCE = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_n,
   output logic evt
);

   localparam logic [7:0] DB_MAX = 8'(DEBOUNCE);

   logic       sync1_q, sync2_q;
   logic [7:0] cnt_q, cnt_d;

   // Counter saturates at DB_MAX so evt holds while the button stays low;
   // any high sample restarts the count, which is the re-arm condition.
   always_comb begin
      cnt_d = cnt_q;
      if (sync2_q)
         cnt_d = 8'd0;
      else if (cnt_q != DB_MAX)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= 8'd0;
      end else begin
         sync1_q <= in_n;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   assign evt = (cnt_q == DB_MAX);

endmodule

// File: rtl/reset_ctrl.sv
// reset_ctrl: system reset sequencer.
//   clk, rst_n : clock and synchronous active-low power-on reset
//   wdt_req    : watchdog reset request (level)
//   btn_n      : asynchronous reset button (active-low, debounced here)
//   cs, we, addr, din, dout : register port
//       0 CAUSE  (W1C), 1 SWRST (write key), 2 COUNT (write clears), 3 STATUS
//   sys_rst    : registered active-high system reset
module reset_ctrl
   import reset_ctrl_pkg::*;
#(
   parameter int unsigned STRETCH  = 16,
   parameter int unsigned DEBOUNCE = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wdt_req,
   input  logic       btn_n,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       sys_rst
);

   localparam logic [7:0] STRETCH_LAST = 8'(STRETCH - 1);

   rst_state_e         state_q;
   logic [7:0]         scnt_q;
   logic               sys_rst_q;
   logic [CAUSE_W-1:0] cause_q, cause_d, cause_set, cause_clr;
   logic [7:0]         rcnt_q, rcnt_d;
   logic               btn_evt, wr_en, sw_evt, hold_req, any_req, run_entry;

   reset_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .in_n  (btn_n),
      .evt   (btn_evt)
   );

   // The bus is dead while the system is held in reset.
   assign wr_en     = cs & we & ~sys_rst_q;
   assign sw_evt    = wr_en & (addr == ADDR_SWRST) & (din == SWRST_KEY);
   assign hold_req  = wdt_req | btn_evt;
   assign any_req   = hold_req | sw_evt;
   assign run_entry = (state_q == ST_RUN) & any_req;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_STRETCH;
         scnt_q    <= 8'd0;
         sys_rst_q <= 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (any_req) begin
                  state_q   <= ST_HOLD;
                  sys_rst_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (!hold_req) begin
                  state_q <= ST_STRETCH;
                  scnt_q  <= 8'd0;
               end
            end
            ST_STRETCH: begin
               if (any_req) begin
                  state_q <= ST_HOLD;
               end else if (scnt_q == STRETCH_LAST) begin
                  state_q   <= ST_RUN;
                  sys_rst_q <= 1'b0;
               end else begin
                  scnt_q <= scnt_q + 8'd1;
               end
            end
            default: begin
               state_q   <= ST_STRETCH;
               scnt_q    <= 8'd0;
               sys_rst_q <= 1'b1;
            end
         endcase
      end
   end

   // Cause: sources set, W1C clears; a set in the same cycle wins.
   always_comb begin
      cause_set            = '0;
      cause_set[CAUSE_WDT] = wdt_req;
      cause_set[CAUSE_BTN] = btn_evt;
      cause_set[CAUSE_SW]  = sw_evt;
      cause_clr = (wr_en && addr == ADDR_CAUSE) ? din[CAUSE_W-1:0] : '0;
      cause_d   = (cause_q & ~cause_clr) | cause_set;
   end

   // Reset counter: an entry in the same cycle as a clear wins.
   always_comb begin
      rcnt_d = rcnt_q;
      if (run_entry) begin
         if (rcnt_q != 8'hFF)
            rcnt_d = rcnt_q + 8'd1;
      end else if (wr_en && addr == ADDR_COUNT) begin
         rcnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cause_q <= CAUSE_RST_VAL;
         rcnt_q  <= 8'd0;
      end else begin
         cause_q <= cause_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      dout = 8'h00;
      case (addr)
         ADDR_CAUSE:  dout = {{(8-CAUSE_W){1'b0}}, cause_q};
         ADDR_SWRST:  dout = 8'h00;
         ADDR_COUNT:  dout = rcnt_q;
         ADDR_STATUS: dout = {6'b0, state_q};
         default:     dout = 8'h00;
      endcase
   end

   assign sys_rst = sys_rst_q;

endmodule
